matrix_uart_printer: RTL and testbench
======================================

# matrix_uart_printer

Parametrised matrix-to-UART formatter. It snapshots a row-major matrix of up to MAX_DIM×MAX_DIM elements of DATA_W bits each. It prints every element as a multi-digit decimal ASCII number, with a space between columns and LF after each row, through the byte-wide UART TX handshake. It sits between matrix storage and the shared UART transmitter. It adds three things over single-digit display: full-width values, abort, and dimension error reporting.

## Interface
- DATA_W, 8: element width, legal range 4..16. Digits per element ND = (DATA_W*301)/1000 + 1.
- MAX_DIM, 5: maximum rows and columns.
- DIM_W, 3: width of the dimension inputs; must hold MAX_DIM.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level/pulse request; honoured only in IDLE.
- abort  in  1  stop printing after the byte currently in flight.
- matrix_row  in  DIM_W  row count, 1..MAX_DIM.
- matrix_col  in  DIM_W  column count, 1..MAX_DIM.
- data_flat  in  MAX_DIM*MAX_DIM*DATA_W  element k = r*matrix_col + c at bits [k*DATA_W +: DATA_W].
- busy  out  1  high from start acceptance until DONE.
- done  out  1  one-cycle pulse when a print completes or is aborted.
- err  out  1  one-cycle pulse when start is rejected because of bad dimensions.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle request to the UART.
- tx_busy  in  1  UART busy.

## Operation
- States are IDLE, LOAD, CONV, SEND, WAIT_START, WAIT_DONE, NEXT, DONE, WAIT_RELEASE.
- IDLE + start:
  - If either dimension is 0 or greater than MAX_DIM, pulse err and stay in IDLE.
  - Otherwise set busy=1, clear r/c counters, go to LOAD.
- LOAD: latch all of data_flat, matrix_row and matrix_col into internal copies. Input changes after this cycle have no effect. Go to CONV.
- CONV: produce one decimal digit per cycle from the current element (value%10 pushed to the digit buffer, value/10 kept).
  - Stop when the quotient is 0. The value 0 yields the single digit "0".
  - No leading zeros, no padding.
  - Go to SEND.
- Byte order per element: optional '-' (0x2D), digits most significant first, then the separator.
  - Separator is 0x20 if c < col-1, otherwise 0x0A.
- SEND: when tx_busy=0, drive tx_data, set tx_start=1, go to WAIT_START.
- WAIT_START: set tx_start=0 and wait for tx_busy=1. Then go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy=0. Then:
  - If bytes remain for this element, go to SEND.
  - Otherwise go to NEXT.
- NEXT: advance c. On c wrap, set c=0 and r+1. After the last element go to DONE, else go to CONV.
- abort: sampled in every non-IDLE state.
  - Outside WAIT_START/WAIT_DONE, go to DONE immediately.
  - Inside WAIT_START/WAIT_DONE, let the current byte finish, then go to DONE.
  - No new tx_start is issued after abort has been seen.
- DONE: busy=0, done=1 for one cycle, go to WAIT_RELEASE.
- WAIT_RELEASE: return to IDLE once start=0. A held start never re-triggers.
- Simultaneous start and abort in IDLE: abort is ignored and start proceeds.

## Timing
- Reset values:
  - busy, done, err, tx_start = 0
  - tx_data = 0x00
  - state = IDLE, counters = 0, caches cleared
- Reset asserted mid-print returns to IDLE immediately. tx_start drops asynchronously and no partial byte request remains.
- start accepted at cycle N:
  - busy=1 at N+1.
  - LOAD at N+1.
  - CONV for d cycles, where d = digit count.
  - First tx_start at N+2+d if tx_busy=0.
- tx_start is always exactly one cycle wide and is never asserted while tx_busy=1.
- An element costs d CONV cycles plus one handshake per byte. There is no added dead cycle between bytes beyond the SEND cycle.
- err is asserted the cycle after the rejected start. busy stays 0.

## Configuration
- MATRIX_PRINT_SIGNED_EN defined:
  - Elements are two's complement.
  - Negative values emit '-' followed by the magnitude. The magnitude is computed in DATA_W+1 bits, so -2^(DATA_W-1) prints correctly (e.g. -128).
- MATRIX_PRINT_SIGNED_EN undefined:
  - Elements are unsigned; '-' is never emitted.
  - 8'h80 prints as "128".

## Test plan
- Unsigned 2×2 [0,7,10,255], UART model with busy for 10 cycles per byte -> exact stream "0 7\n10 255\n" (11 bytes), done pulses once, busy=0 afterwards.
- matrix_row=0 and, separately, matrix_col=6 with MAX_DIM=5 -> one err pulse, no tx_start, busy stays 0.
- start held high for the whole print of 1×1 [42] -> "42\n" once, no second print until start falls and rises again.
- abort asserted during the second byte of 1×3 [123,4,5] -> bytes "1","2" sent, no further tx_start, done pulse after tx_busy falls.
- MATRIX_PRINT_SIGNED_EN with 1×2 [8'h80, 8'h05] -> "-128 5\n". Without the macro, the same data -> "128 5\n".
- rst_n low mid-print, then a new 1×1 [9] -> outputs at reset values during reset, then exactly "9\n".

Source files
------------

// File: rtl/matrix_uart_printer.sv
// ============================================================================
// Module   : matrix_uart_printer
// Brief    : Snapshots a row-major matrix and prints each element as a
//            multi-digit decimal ASCII number over a byte-wide UART TX
//            handshake. Columns are separated by spaces and rows end in LF.
//            Supports abort and reports bad dimensions.
// Options  : MATRIX_PRINT_SIGNED_EN - treat elements as two's complement
//            and print a leading '-' for negative values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_uart_printer #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5,
  parameter int DIM_W   = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [DIM_W-1:0]                  matrix_row,
  input  logic [DIM_W-1:0]                  matrix_col,
  input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] data_flat,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [7:0]                        tx_data,
  output logic                              tx_start,
  input  logic                              tx_busy
);

  // Digits needed for the largest magnitude (log10(2) ~ 0.301).
  localparam int ND    = (DATA_W * 301) / 1000 + 1;
  localparam int NE    = MAX_DIM * MAX_DIM;
  localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1;
  // Byte pointer covers optional '-', ND digits and the separator.
  localparam int BP_W  = $clog2(ND + 2);

  localparam logic [DIM_W-1:0] MAXD = DIM_W'(MAX_DIM);
  localparam logic [DATA_W:0]  TEN  = (DATA_W + 1)'(10);

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    LOAD         = 4'd1,
    CONV         = 4'd2,
    SEND         = 4'd3,
    WAIT_START   = 4'd4,
    WAIT_DONE    = 4'd5,
    NEXT         = 4'd6,
    DONE         = 4'd7,
    WAIT_RELEASE = 4'd8
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mat_q [NE];
  logic [DIM_W-1:0]    rows_q, cols_q;
  logic [DIM_W-1:0]    r_q, c_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W:0]     quot_q;
  logic                neg_q;
  logic [3:0]          digs_q [ND];
  logic [BP_W-1:0]     ndig_q;
  logic [BP_W-1:0]     bptr_q;
  logic                abort_seen_q;
  logic [7:0]          last_byte_q;
  logic                err_q;

  logic                bad_dim;
  logic                last_elem;
  logic                elem_end;
  logic [IDX_W-1:0]    idx_nxt;
  logic [DATA_W:0]     w_quo;
  logic [3:0]          w_dig;
  logic [DATA_W+1:0]   ld_dec, nxt_dec;
  logic [BP_W-1:0]     pos, sel;
  logic [3:0]          dig_sel;
  logic [7:0]          cur_byte;

  // Returns {negative, magnitude}; magnitude is one bit wider so the most
  // negative value still has a representable magnitude.
  function automatic logic [DATA_W+1:0] decode(input logic [DATA_W-1:0] v);
    logic [DATA_W:0] ext;
`ifdef MATRIX_PRINT_SIGNED_EN
    ext = {v[DATA_W-1], v};
    if (v[DATA_W-1]) return {1'b1, -ext};
    return {1'b0, ext};
`else
    ext = {1'b0, v};
    return {1'b0, ext};
`endif
  endfunction

  assign bad_dim   = (matrix_row == '0) || (matrix_row > MAXD) ||
                     (matrix_col == '0) || (matrix_col > MAXD);
  assign last_elem = (r_q == rows_q - DIM_W'(1)) && (c_q == cols_q - DIM_W'(1));
  assign elem_end  = (bptr_q == ndig_q + BP_W'(neg_q));
  assign idx_nxt   = (idx_q == IDX_W'(NE - 1)) ? '0 : idx_q + IDX_W'(1);
  assign w_quo     = quot_q / TEN;
  assign w_dig     = 4'(quot_q - w_quo * TEN);
  assign ld_dec    = decode(data_flat[DATA_W-1:0]);
  assign nxt_dec   = decode(mat_q[idx_nxt]);
  assign err       = err_q;

  // Select the byte at bptr_q: optional '-', digits MSD first, separator.
  always_comb begin
    pos     = bptr_q - BP_W'(neg_q);
    sel     = ndig_q - BP_W'(1) - pos;
    dig_sel = 4'h0;
    for (int i = 0; i < ND; i++) begin
      if (sel == BP_W'(i)) dig_sel = digs_q[i];
    end
    if (neg_q && (bptr_q == '0))        cur_byte = 8'h2D;
    else if (pos < ndig_q)              cur_byte = 8'h30 + {4'h0, dig_sel};
    else if (c_q < cols_q - DIM_W'(1))  cur_byte = 8'h20;
    else                                cur_byte = 8'h0A;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    tx_data  = last_byte_q;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && !bad_dim) state_d = LOAD;
      end
      LOAD: state_d = abort ? DONE : CONV;
      CONV: begin
        if (abort)              state_d = DONE;
        else if (w_quo == '0)   state_d = SEND;
      end
      SEND: begin
        tx_data = cur_byte;
        if (abort) state_d = DONE;
        else if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = WAIT_START;
        end
      end
      WAIT_START: if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (abort || abort_seen_q) state_d = DONE;
          else if (elem_end)         state_d = NEXT;
          else                       state_d = SEND;
        end
      end
      NEXT: begin
        if (abort || last_elem) state_d = DONE;
        else                    state_d = CONV;
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        busy = 1'b0;
        if (!start) state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: snapshot, digit conversion, byte/element counters, flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NE; k++) mat_q[k] <= '0;
      for (int i = 0; i < ND; i++) digs_q[i] <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      r_q          <= '0;
      c_q          <= '0;
      idx_q        <= '0;
      quot_q       <= '0;
      neg_q        <= 1'b0;
      ndig_q       <= '0;
      bptr_q       <= '0;
      abort_seen_q <= 1'b0;
      last_byte_q  <= 8'h00;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          abort_seen_q <= 1'b0;
          if (start) begin
            if (bad_dim) begin
              err_q <= 1'b1;
            end else begin
              r_q   <= '0;
              c_q   <= '0;
              idx_q <= '0;
            end
          end
        end
        LOAD: begin
          for (int k = 0; k < NE; k++) mat_q[k] <= data_flat[k*DATA_W +: DATA_W];
          rows_q            <= matrix_row;
          cols_q            <= matrix_col;
          {neg_q, quot_q}   <= ld_dec;
          ndig_q            <= '0;
          bptr_q            <= '0;
        end
        CONV: begin
          for (int i = 0; i < ND; i++) begin
            if (ndig_q == BP_W'(i)) digs_q[i] <= w_dig;
          end
          ndig_q <= ndig_q + BP_W'(1);
          quot_q <= w_quo;
        end
        SEND: if (tx_start) last_byte_q <= cur_byte;
        WAIT_START: if (abort) abort_seen_q <= 1'b1;
        WAIT_DONE: begin
          if (abort) abort_seen_q <= 1'b1;
          if (!tx_busy && !elem_end) bptr_q <= bptr_q + BP_W'(1);
        end
        NEXT: begin
          if (!last_elem) begin
            if (c_q == cols_q - DIM_W'(1)) begin
              c_q <= '0;
              r_q <= r_q + DIM_W'(1);
            end else begin
              c_q <= c_q + DIM_W'(1);
            end
            idx_q           <= idx_nxt;
            {neg_q, quot_q} <= nxt_dec;
            ndig_q          <= '0;
            bptr_q          <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matrix_uart_printer.sv
// ============================================================================
// Module   : tb_matrix_uart_printer
// Brief    : Directed bench for matrix_uart_printer with a UART model that
//            stays busy for 10 cycles per byte and a byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_uart_printer;
  localparam int DATA_W  = 8;
  localparam int MAX_DIM = 5;
  localparam int DIM_W   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [DIM_W-1:0] matrix_row = '0;
  logic [DIM_W-1:0] matrix_col = '0;
  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] data_flat = '0;
  logic busy, done, err, tx_start;
  logic [7:0] tx_data;
  logic tx_busy = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int rx_cnt = 0;
  int done_cnt = 0;
  logic done_busy = 1'b0;
  logic prev_start = 1'b0;
  logic smp_start = 1'b0;
  int ucnt = 0;

  matrix_uart_printer #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .matrix_row(matrix_row), .matrix_col(matrix_col), .data_flat(data_flat),
    .busy(busy), .done(done), .err(err), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Byte monitor and scoreboard compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (tx_start) begin
      rx_cnt <= rx_cnt + 1;
      chk("tx_start_while_busy", 32'(tx_busy), 32'd0);
      chk("tx_start_width", 32'(prev_start), 32'd0);
      if (exp_q.size() == 0) chk("unexpected_byte", 32'(exp_q.size()), 32'd1);
      else                   chk("byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
    if (done) begin
      done_cnt  <= done_cnt + 1;
      done_busy <= tx_busy;
    end
    prev_start <= tx_start;
    smp_start  <= tx_start;
  end

  // UART model: accepts a request and stays busy for 10 cycles.
  always @(posedge clk) begin
    if (ucnt != 0) begin
      ucnt <= ucnt - 1;
      if (ucnt == 1) tx_busy <= 1'b0;
    end else if (smp_start) begin
      tx_busy <= 1'b1;
      ucnt    <= 10;
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic set_elem(input int k, input logic [DATA_W-1:0] v);
    data_flat[k*DATA_W +: DATA_W] = v;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base, input int bound);
    int ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (done_cnt != base) begin
        ok = 1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_rx(input string tag, input int target, input int bound);
    int ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (rx_cnt >= target) begin
        ok = 1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_uart_idle(input int bound);
    int ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (!tx_busy) begin
        ok = 1;
        break;
      end
    end
    chk("uart_idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    int base_rx, base_dn, lat;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Unsigned 2x2 [0,7,10,255] with start-to-first-byte latency
    matrix_row = 3'd2; matrix_col = 3'd2; data_flat = '0;
    set_elem(0, 8'd0); set_elem(1, 8'd7); set_elem(2, 8'd10); set_elem(3, 8'd255);
    push_str("0 7\n10 255\n");
    base_rx = rx_cnt; base_dn = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_accept", 32'(busy), 32'd1);
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (tx_start) begin
        lat = i;
        break;
      end
    end
    chk("first_tx_latency", 32'(lat), 32'd3);
    wait_done("done_timeout_2x2", base_dn, 1000);
    repeat (5) @(posedge clk);
    chk("done_pulses_2x2", 32'(done_cnt - base_dn), 32'd1);
    chk("busy_after_2x2", 32'(busy), 32'd0);
    chk("bytes_2x2", 32'(rx_cnt - base_rx), 32'd11);
    chk("queue_empty_2x2", 32'(exp_q.size()), 32'd0);

    // Bad dimensions: row = 0, then col = 6
    for (int t = 0; t < 2; t++) begin
      matrix_row = (t == 0) ? 3'd0 : 3'd1;
      matrix_col = (t == 0) ? 3'd2 : 3'd6;
      base_rx = rx_cnt;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("err_pulse", 32'(err), 32'd1);
      chk("err_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("err_one_cycle", 32'(err), 32'd0);
      repeat (10) @(posedge clk);
      chk("err_no_tx", 32'(rx_cnt - base_rx), 32'd0);
      chk("err_busy_later", 32'(busy), 32'd0);
    end

    // Held start, 1x1 [42]
    matrix_row = 3'd1; matrix_col = 3'd1; data_flat = '0;
    set_elem(0, 8'd42);
    push_str("42\n");
    base_rx = rx_cnt; base_dn = done_cnt;
    @(negedge clk);
    start = 1'b1;
    wait_done("done_timeout_held", base_dn, 500);
    repeat (40) @(posedge clk);
    chk("held_bytes", 32'(rx_cnt - base_rx), 32'd3);
    chk("held_done_once", 32'(done_cnt - base_dn), 32'd1);
    chk("held_busy", 32'(busy), 32'd0);
    chk("queue_empty_held", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Abort during the second byte of 1x3 [123,4,5]
    matrix_row = 3'd1; matrix_col = 3'd3; data_flat = '0;
    set_elem(0, 8'd123); set_elem(1, 8'd4); set_elem(2, 8'd5);
    push_str("12");
    base_rx = rx_cnt; base_dn = done_cnt;
    pulse_start();
    wait_rx("abort_second_byte_timeout", base_rx + 2, 500);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_done("done_timeout_abort", base_dn, 200);
    chk("abort_done_after_busy", 32'(done_busy), 32'd0);
    repeat (30) @(posedge clk);
    chk("abort_bytes", 32'(rx_cnt - base_rx), 32'd2);
    chk("abort_done_once", 32'(done_cnt - base_dn), 32'd1);
    chk("queue_empty_abort", 32'(exp_q.size()), 32'd0);

    // 1x2 [0x80, 0x05]: signedness follows the build option
    matrix_row = 3'd1; matrix_col = 3'd2; data_flat = '0;
    set_elem(0, 8'h80); set_elem(1, 8'h05);
`ifdef MATRIX_PRINT_SIGNED_EN
    push_str("-128 5\n");
`else
    push_str("128 5\n");
`endif
    base_dn = done_cnt;
    pulse_start();
    wait_done("done_timeout_sign", base_dn, 1000);
    repeat (5) @(posedge clk);
    chk("queue_empty_sign", 32'(exp_q.size()), 32'd0);

    // Reset mid-print, then 1x1 [9]
    matrix_row = 3'd1; matrix_col = 3'd3; data_flat = '0;
    set_elem(0, 8'd123); set_elem(1, 8'd4); set_elem(2, 8'd5);
    push_str("1");
    base_rx = rx_cnt;
    pulse_start();
    wait_rx("reset_first_byte_timeout", base_rx + 1, 500);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_tx_start", 32'(tx_start), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_tx_start_held", 32'(tx_start), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wait_uart_idle(50);
    matrix_row = 3'd1; matrix_col = 3'd1; data_flat = '0;
    set_elem(0, 8'd9);
    push_str("9\n");
    base_rx = rx_cnt; base_dn = done_cnt;
    pulse_start();
    wait_done("done_timeout_after_reset", base_dn, 500);
    repeat (20) @(posedge clk);
    chk("after_reset_bytes", 32'(rx_cnt - base_rx), 32'd2);
    chk("queue_empty_after_reset", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
